regser_rx: RTL and testbench
============================

Name: regser_rx

Overview:
- Serial-in, parallel-out frame receiver; the receive end of the team's parallel-load shift-register transmitter.
- Frame format on line S, one bit per shiftEN strobe:
  - idle line is 1
  - start bit is 0
  - WIDTH data bits, LSB first
  - stop bit is 1
- Assembles each frame into a WIDTH-bit word and holds it with a valid/ack handshake.
- Flags framing errors and overruns.
- Sits between the serial link and the consuming datapath.

Parameters:
- WIDTH, 4, number of data bits per frame (legal range 2..16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- shiftEN  input  1  bit strobe; S is sampled only on rising edges where shiftEN=1.
- S  input  1  serial line; idles high.
- ack  input  1  consumer acknowledge; clears valid.
- content  output  WIDTH  last correctly received word.
- valid  output  1  content holds an unacknowledged word.
- busy  output  1  a frame is in progress (state is not IDLE).
- frame_err  output  1  one-cycle pulse when a frame's stop bit is sampled as 0.
- overrun  output  1  sticky; set when a word is overwritten while valid=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, bit counter=0, shift register=all 1s
  - content=0, valid=0, busy=0, frame_err=0, overrun=0
  - Takes effect immediately, mid-frame included; the partial frame is discarded.
- All outputs are registered and change only on the rising edge of clk or on reset assertion.
- Cycles with shiftEN=0 change no state except:
  - ack handling
  - the frame_err pulse returning to 0
- FSM states: IDLE, DATA, STOP.
  - IDLE: on a strobe with S=0 (start bit) go to DATA and set counter=0. A strobe with S=1 stays in IDLE.
  - DATA: on each strobe:
    - shift right, inserting S at bit WIDTH-1, so the first data bit ends in bit 0
    - counter increments
    - on the strobe that captures data bit WIDTH-1 (counter==WIDTH-1), go to STOP
  - STOP, on a strobe:
    - S=1: content <= shift register; valid <= 1; go to IDLE.
    - S=0: frame_err pulses 1 for exactly one clk cycle; content, valid and overrun are unchanged; go to IDLE.
  - A 0 on S in IDLE immediately after a bad stop bit is treated as a new start bit. There is no break detection.
- Latency: content and valid update on the same edge as the stop-bit strobe.
  - Minimum frame length: WIDTH+2 strobes.
  - Back-to-back frames are legal (a start bit on the strobe after the stop strobe).
- busy=1 in DATA and STOP, and 0 in IDLE.
- Handshake:
  - valid stays 1 until a cycle with ack=1; it clears on that edge.
  - ack while valid=0 has no effect.
- Good frame completes while valid=1 and ack=0:
  - content is overwritten with the new word
  - valid stays 1
  - overrun is set to 1
- Good frame completes on the same edge as ack=1: content is updated, valid stays 1, overrun is not set. Completion wins over ack.
- overrun clears only on reset.
- Bit counter width is clog2(WIDTH). The counter never wraps inside DATA.

Test Plan:
- WIDTH=4. Strobe every cycle, S = 0,0,1,0,1,1 (start, data 0/1/0/1 LSB first, stop) -> on the stop edge content=4'hA, valid=1, busy=0. Pulse ack -> valid=0; content stays 4'hA.
- Strobe only every 3rd cycle, same frame as above -> same result. Nothing changes on non-strobe cycles. busy is 1 from the start edge through the stop edge.
- Frame with data 4'h5 and a stop bit of 0 -> frame_err is high for exactly 1 cycle; content and valid are unchanged; state returns to IDLE. A following good frame with data 4'h3 -> content=4'h3.
- Two good frames (data 4'hC then 4'h6), no ack -> content=4'h6, valid=1, overrun=1. Repeat, but assert ack on the second stop edge -> content=4'h6, valid=1, overrun=0.
- Assert reset=0 asynchronously after the start bit plus 2 data bits -> all outputs go to 0 immediately. Release, send data 4'h9 -> content=4'h9 with no corruption from the partial frame.
- Line held at 1 for 20 strobes -> state stays IDLE, busy=0, valid=0.

Source files
------------

// File: rtl/regser_rx_if.sv
// regser_rx_if: strobe/data/handshake bundle between a serial link driver
// and the regser_rx frame receiver.
//   shiftEN, S, ack                        : driven by the link/consumer side
//   content, valid, busy, frame_err, overrun : driven by the receiver
interface regser_rx_if #(
  parameter int WIDTH = 4
);
  logic             shiftEN;
  logic             S;
  logic             ack;
  logic [WIDTH-1:0] content;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output shiftEN, S, ack,
    input  content, valid, busy, frame_err, overrun
  );

  modport slave (
    input  shiftEN, S, ack,
    output content, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/regser_rx.sv
// regser_rx: serial-in, parallel-out frame receiver.
// Frame on S, one bit per shiftEN strobe: start(0), WIDTH data bits LSB
// first, stop(1); the line idles high.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   bus.shiftEN    bit strobe; S sampled only when 1
//   bus.S          serial line
//   bus.ack        consumer acknowledge, clears valid
//   bus.content    last correctly received word
//   bus.valid      content holds an unacknowledged word
//   bus.busy       frame in progress
//   bus.frame_err  one-cycle pulse on a stop bit sampled as 0
//   bus.overrun    sticky; a valid word was overwritten
module regser_rx #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  regser_rx_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_content;
  logic             r_valid;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '1;
      r_content   <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (bus.ack) r_valid <= 1'b0;

      if (bus.shiftEN) begin
        unique case (r_state)
          IDLE: begin
            if (!bus.S) begin
              r_state <= DATA;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= {bus.S, r_shift[WIDTH-1:1]};
            // Hold the counter on the last bit so it never wraps.
            if (r_cnt == LAST) begin
              r_state <= STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STOP: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (bus.S) begin
              // Completion overrides a coincident ack; overrun only when
              // the previous word was neither consumed nor being consumed.
              if (r_valid && !bus.ack) r_overrun <= 1'b1;
              r_content <= r_shift;
              r_valid   <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.content   = r_content;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_regser_rx.sv
module tb_regser_rx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state, tracked per frame / per handshake event.
  logic [W-1:0] m_content = '0;
  logic         m_valid   = 1'b0;
  logic         m_overrun = 1'b0;

  regser_rx_if #(.WIDTH(W)) bus ();

  regser_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_content = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // Model of a completed frame at its stop strobe.
  task automatic model_stop(input logic [W-1:0] d, input logic stop, input logic ack_s);
    if (stop) begin
      if (m_valid && !ack_s) m_overrun = 1'b1;
      m_content = d;
      m_valid   = 1'b1;
    end else if (ack_s) begin
      m_valid = 1'b0;
    end
  endtask

  // Drives one frame; gap non-strobe cycles (random S) precede each strobe.
  task automatic send_frame(input logic [W-1:0] d, input logic stop,
                            input int unsigned gap, input logic ack_s);
    logic [W+1:0] f;
    f = {stop, d, 1'b0};
    for (int unsigned i = 0; i < W + 2; i++) begin
      for (int unsigned g = 0; g < gap; g++) begin
        bus.shiftEN = 1'b0;
        bus.S       = 1'($urandom);
        tick();
      end
      bus.shiftEN = 1'b1;
      bus.S       = f[i];
      bus.ack     = (i == W + 1) ? ack_s : 1'b0;
      tick();
      bus.shiftEN = 1'b0;
      bus.S       = 1'b1;
      bus.ack     = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.shiftEN = 1'b0;
    bus.S       = 1'b1;
    bus.ack     = 1'b0;
    reset       = 1'b0;
    repeat (2) tick();
    checks++; if (bus.content !== 4'h0) begin errors++; $display("FAIL reset_content got %h want 0", bus.content); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_basic_frame();
    logic [5:0] bits;
    bits = 6'b110100; // sent LSB first: 0,0,1,0,1,1
    for (int unsigned i = 0; i < 6; i++) begin
      bus.shiftEN = 1'b1;
      bus.S       = bits[i];
      tick();
      if (i < 5) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy bit %0d got %b want 1", i, bus.busy); end
      end
    end
    bus.shiftEN = 1'b0;
    model_stop(4'hA, 1'b1, 1'b0);
    checks++; if (bus.content !== 4'hA) begin errors++; $display("FAIL basic_content got %h want a", bus.content); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", bus.busy); end
    ack_pulse();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid got %b want 0", bus.valid); end
    checks++; if (bus.content !== 4'hA) begin errors++; $display("FAIL basic_ack_content got %h want a", bus.content); end
  endtask

  task automatic test_slow_strobe();
    logic [5:0] bits;
    logic [W-1:0] c0;
    logic v0, b0;
    bits = 6'b110100;
    for (int unsigned i = 0; i < 6; i++) begin
      c0 = bus.content; v0 = bus.valid; b0 = bus.busy;
      for (int unsigned g = 0; g < 2; g++) begin
        bus.shiftEN = 1'b0;
        bus.S       = 1'($urandom);
        tick();
        checks++;
        if (bus.content !== c0 || bus.valid !== v0 || bus.busy !== b0) begin
          errors++;
          $display("FAIL slow_hold bit %0d got c=%h v=%b b=%b want c=%h v=%b b=%b",
                   i, bus.content, bus.valid, bus.busy, c0, v0, b0);
        end
      end
      bus.shiftEN = 1'b1;
      bus.S       = bits[i];
      tick();
      bus.shiftEN = 1'b0;
      checks++;
      if (bus.busy !== (i < 5)) begin errors++; $display("FAIL slow_busy bit %0d got %b want %b", i, bus.busy, (i < 5)); end
    end
    model_stop(4'hA, 1'b1, 1'b0);
    checks++; if (bus.content !== 4'hA) begin errors++; $display("FAIL slow_content got %h want a", bus.content); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL slow_valid got %b want 1", bus.valid); end
    ack_pulse();
  endtask

  task automatic test_frame_err();
    send_frame(4'h5, 1'b0, 0, 1'b0);
    model_stop(4'h5, 1'b0, 1'b0);
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %b want 1", bus.frame_err); end
    checks++; if (bus.content !== m_content) begin errors++; $display("FAIL ferr_content got %h want %h", bus.content, m_content); end
    checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL ferr_valid got %b want %b", bus.valid, m_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_width got %b want 0", bus.frame_err); end
    send_frame(4'h3, 1'b1, 0, 1'b0);
    model_stop(4'h3, 1'b1, 1'b0);
    checks++; if (bus.content !== 4'h3) begin errors++; $display("FAIL ferr_next_content got %h want 3", bus.content); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_next_flag got %b want 0", bus.frame_err); end
    ack_pulse();
  endtask

  task automatic test_overrun();
    send_frame(4'hC, 1'b1, 0, 1'b0); model_stop(4'hC, 1'b1, 1'b0);
    send_frame(4'h6, 1'b1, 0, 1'b0); model_stop(4'h6, 1'b1, 1'b0);
    checks++; if (bus.content !== 4'h6) begin errors++; $display("FAIL ovr_content got %h want 6", bus.content); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", bus.valid); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", bus.overrun); end
    ack_pulse();
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_reset();
    tick();
    send_frame(4'hC, 1'b1, 0, 1'b0); model_stop(4'hC, 1'b1, 1'b0);
    send_frame(4'h6, 1'b1, 0, 1'b1); model_stop(4'h6, 1'b1, 1'b1);
    checks++; if (bus.content !== 4'h6) begin errors++; $display("FAIL ovr_ack_content got %h want 6", bus.content); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_ack_valid got %b want 1", bus.valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_overrun got %b want 0", bus.overrun); end
    ack_pulse();
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b0110; // start 0, data bits 1,1 (LSB first)
    for (int unsigned i = 0; i < 3; i++) begin
      bus.shiftEN = 1'b1;
      bus.S       = bits[i];
      tick();
    end
    bus.shiftEN = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b want 1", bus.busy); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.content !== 4'h0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL areset_outputs got c=%h v=%b b=%b fe=%b ov=%b want all 0",
               bus.content, bus.valid, bus.busy, bus.frame_err, bus.overrun);
    end
    model_reset();
    @(negedge clk); reset = 1'b1;
    tick();
    send_frame(4'h9, 1'b1, 0, 1'b0); model_stop(4'h9, 1'b1, 1'b0);
    checks++; if (bus.content !== 4'h9) begin errors++; $display("FAIL areset_content got %h want 9", bus.content); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL areset_valid got %b want 1", bus.valid); end
    ack_pulse();
  endtask

  task automatic test_idle_line();
    for (int unsigned i = 0; i < 20; i++) begin
      bus.shiftEN = 1'b1;
      bus.S       = 1'b1;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_line strobe %0d got busy=%b valid=%b want 0 0", i, bus.busy, bus.valid);
      end
    end
    bus.shiftEN = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic stop, ack_s;
    int unsigned gap, idle;
    for (int unsigned n = 0; n < 60; n++) begin
      d     = W'($urandom);
      stop  = ($urandom_range(3) != 0);
      ack_s = 1'($urandom);
      gap   = $urandom_range(2);
      send_frame(d, stop, gap, ack_s);
      model_stop(d, stop, ack_s);
      checks++;
      if (bus.content !== m_content || bus.valid !== m_valid || bus.overrun !== m_overrun ||
          bus.frame_err !== !stop || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_frame %0d got c=%h v=%b ov=%b fe=%b b=%b want c=%h v=%b ov=%b fe=%b b=0",
                 n, bus.content, bus.valid, bus.overrun, bus.frame_err, bus.busy,
                 m_content, m_valid, m_overrun, !stop);
      end
      // Optional idle cycles (possibly 0 for back-to-back), with random ack.
      idle = $urandom_range(2);
      for (int unsigned k = 0; k < idle; k++) begin
        bus.ack = 1'($urandom);
        if (bus.ack) m_valid = 1'b0;
        tick();
        bus.ack = 1'b0;
      end
    end
    checks++;
    if (bus.valid !== m_valid || bus.overrun !== m_overrun) begin
      errors++;
      $display("FAIL rand_final got v=%b ov=%b want v=%b ov=%b", bus.valid, bus.overrun, m_valid, m_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_slow_strobe();
    test_frame_err();
    test_overrun();
    test_async_reset();
    test_idle_line();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
